// File: rtl/sample_writer.sv
// sample_writer: producer side of the averaging path.
// Buffers an upstream valid/ready sample stream in a small skid FIFO and
// forwards one sample per read strobe to the averager. It also tracks how
// full the averaging window is.
// Optional build macro SAMPLE_WRITER_DECIM_EN: forward only every DECIM-th
// popped sample; the others are popped and discarded.
module sample_writer #(
  parameter int data_width = 8,
  parameter int N          = 4096,
  parameter int FIFO_DEPTH = 4,
  parameter int DECIM      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [data_width-1:0] in_data,
  output logic                  in_ready,
  input  logic                  enable,
  output logic                  read,
  output logic [data_width-1:0] data_out,
  output logic [$clog2(N)-1:0]  sample_count,
  output logic                  window_full,
  output logic                  window_done
);

  localparam int CW = $clog2(N);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  // Reject parameter sets the pointer and counter arithmetic cannot handle.
  if ((N < 2) || ((1 << CW) != N)) begin : g_bad_n
    $error("N must be a power of 2 and >= 2");
  end
  if ((FIFO_DEPTH < 2) || ((1 << AW) != FIFO_DEPTH)) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of 2 and >= 2");
  end
  if (DECIM < 1) begin : g_bad_decim
    $error("DECIM must be >= 1");
  end

  typedef enum logic {
    PRIME = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t state, next_state;

  logic [data_width-1:0] mem [FIFO_DEPTH];
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        fifo_full;
  logic        fifo_empty;
  logic        push;
  logic        pop;
  logic        fwd;
  logic        wrap;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // Ready depends only on occupancy: a full FIFO refuses even when it pops
  // on the same edge, which keeps in_ready free of any path from enable.
  assign in_ready   = !fifo_full;
  assign push       = in_valid && !fifo_full;
  assign pop        = enable && !fifo_empty;
  // The forwarded sample that completes an N-sample window.
  assign wrap       = fwd && (sample_count == CNT_LAST);

`ifdef SAMPLE_WRITER_DECIM_EN
  localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [DW-1:0] DEC_LAST = DW'(DECIM - 1);

  logic [DW-1:0] dec_cnt;

  // Only the pop that finds the phase counter at zero is forwarded.
  assign fwd = pop && (dec_cnt == '0);

  // Decimation phase advances on every pop, forwarded or discarded.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dec_cnt <= '0;
    end else if (pop) begin
      dec_cnt <= (dec_cnt == DEC_LAST) ? '0 : dec_cnt + 1'b1;
    end
  end
`else
  assign fwd = pop;
`endif

  // FIFO storage: data only, contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= in_data;
    end
  end

  // FIFO pointers; reset empties the FIFO and discards anything buffered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Output stage: the strobe is high for the cycle after a forwarding pop,
  // and data_out holds the last forwarded sample in between.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      read        <= 1'b0;
      data_out    <= '0;
      window_done <= 1'b0;
    end else begin
      read        <= fwd;
      window_done <= wrap;
      if (fwd) begin
        data_out <= mem[rd_ptr[AW-1:0]];
      end
    end
  end

  // Forwarded-sample counter modulo N.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sample_count <= '0;
    end else if (fwd) begin
      sample_count <= wrap ? '0 : sample_count + 1'b1;
    end
  end

  // Window-fill state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= PRIME;
    end else begin
      state <= next_state;
    end
  end

  // Next state: leave PRIME on the first completed window, then stay in RUN.
  always_comb begin
    next_state = state;
    case (state)
      PRIME:   if (wrap) next_state = RUN;
      RUN:     next_state = RUN;
      default: next_state = PRIME;
    endcase
  end

  assign window_full = (state == RUN);

endmodule

// File: tb/tb_sample_writer.sv
// Self-checking bench for sample_writer (N=4, FIFO_DEPTH=4, DECIM=2).
// A queue-based reference model predicts every output each cycle; directed
// sequences pin the model with hand-computed expectations.
module tb_sample_writer;

  localparam int DW    = 8;
  localparam int NW    = 4;
  localparam int DEPTH = 4;
  localparam int DEC   = 2;
  localparam int CW    = $clog2(NW);
`ifdef SAMPLE_WRITER_DECIM_EN
  localparam int MD = DEC;
`else
  localparam int MD = 1;
`endif

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          enable;
  logic          read;
  logic [DW-1:0] data_out;
  logic [CW-1:0] sample_count;
  logic          window_full;
  logic          window_done;

  sample_writer #(
    .data_width(DW),
    .N(NW),
    .FIFO_DEPTH(DEPTH),
    .DECIM(DEC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .enable(enable),
    .read(read),
    .data_out(data_out),
    .sample_count(sample_count),
    .window_full(window_full),
    .window_done(window_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int            q[$];
  int            fwd_total = 0;
  int            pop_total = 0;
  logic          exp_read  = 1'b0;
  logic [DW-1:0] exp_data  = '0;
  logic          exp_done  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge reset) begin
    bit do_push;
    bit do_pop;
    int v;
    if (!reset) begin
      q.delete();
      fwd_total = 0;
      pop_total = 0;
      exp_read  = 1'b0;
      exp_data  = '0;
      exp_done  = 1'b0;
    end else begin
      do_push  = in_valid && (q.size() < DEPTH);
      do_pop   = enable && (q.size() > 0);
      exp_read = 1'b0;
      exp_done = 1'b0;
      if (do_pop) begin
        v = q.pop_front();
        if (pop_total % MD == 0) begin
          fwd_total++;
          exp_read = 1'b1;
          exp_data = v[DW-1:0];
          exp_done = (fwd_total % NW == 0);
        end
        pop_total++;
      end
      if (do_push) q.push_back(int'(in_data));
    end
  end

  // ---------------- compare process ----------------
  int seen[$];
  int seen_cyc[$];
  int seen_done[$];
  int seen_full[$];

  always @(negedge clk) begin
    if (reset && chk_en) begin
      check("read", 32'(read), 32'(exp_read));
      check("data_out", 32'(data_out), 32'(exp_data));
      check("sample_count", 32'(sample_count), 32'(fwd_total % NW));
      check("window_full", 32'(window_full), 32'(fwd_total >= NW));
      check("window_done", 32'(window_done), 32'(exp_done));
      check("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
      if (read === 1'b1) begin
        seen.push_back(int'(data_out));
        seen_cyc.push_back(cyc);
        seen_done.push_back(int'(window_done));
        seen_full.push_back(int'(window_full));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic clear_seen();
    seen.delete();
    seen_cyc.delete();
    seen_done.delete();
    seen_full.delete();
  endtask

  // Called at a falling edge; asserts reset between edges and checks the
  // outputs clear without any clock edge.
  task automatic do_reset();
    #2 reset = 1'b0;
    #1;
    check("rst_read", 32'(read), 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_sample_count", 32'(sample_count), 32'd0);
    check("rst_window_full", 32'(window_full), 32'd0);
    check("rst_window_done", 32'(window_done), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    enable   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    clear_seen();
  endtask

  // Holds a sample on the input until it is accepted; starts and ends at a
  // falling edge and returns the index of the accepting edge.
  task automatic push(input int v, output int acc_cyc);
    int   n;
    logic acc;
    in_valid = 1'b1;
    in_data  = v[DW-1:0];
    n = 0;
    forever begin
      acc = in_ready;
      @(posedge clk);
      if (acc) break;
      n++;
      if (n > 50) begin
        tests++;
        fails++;
        $display("FAIL push_timeout: value %0d not accepted after %0d cycles, expected acceptance", v, n);
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    acc_cyc = cyc;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  int a0;
  int a5;
  int e;
  int th;

  initial begin
    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    enable   = 1'b0;
    repeat (2) @(negedge clk);
    check("init_in_ready", 32'(in_ready), 32'd1);
    check("init_read", 32'(read), 32'd0);
    #2 reset = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;

`ifndef SAMPLE_WRITER_DECIM_EN
    // Latency and order: 8,16,24,64 on consecutive edges.
    enable = 1'b1;
    push(8, a0);
    push(16, e);
    push(24, e);
    push(64, e);
    idle(6);
    check("lat_count", seen.size(), 4);
    check("lat_d0", seen[0], 8);
    check("lat_d1", seen[1], 16);
    check("lat_d2", seen[2], 24);
    check("lat_d3", seen[3], 64);
    check("lat_first_read_cycle", seen_cyc[0], a0 + 1);
    check("lat_last_read_cycle", seen_cyc[3], a0 + 4);
    check("lat_done_early", seen_done[0] + seen_done[1] + seen_done[2], 0);
    check("lat_done_64", seen_done[3], 1);
    check("lat_full_before", seen_full[2], 0);
    check("lat_full_64", seen_full[3], 1);
    check("lat_sample_count", 32'(sample_count), 32'd0);
    check("lat_window_full", 32'(window_full), 32'd1);

    // Reset while a read is in flight.
    in_valid = 1'b1;
    in_data  = 8'd99;
    @(negedge clk);
    @(negedge clk);
    check("mid_read_pending", 32'(read), 32'd1);
    do_reset();

    // Backpressure, then full FIFO with a pop on the same edge.
    enable = 1'b0;
    for (int i = 1; i <= 4; i++) push(i, e);
    check("bp_in_ready_full", 32'(in_ready), 32'd0);
    in_valid = 1'b1;
    in_data  = 8'd5;
    @(negedge clk);
    check("bp_held", 32'(in_ready), 32'd0);
    @(negedge clk);
    enable = 1'b1;
    e = cyc;
    push(5, a5);
    check("bp_push_after_pop_edge", a5, e + 2);
    push(6, a0);
    idle(8);
    check("bp_count", seen.size(), 6);
    for (int i = 0; i < 6; i++) begin
      check("bp_data", seen[i], i + 1);
      check("bp_no_gap", seen_cyc[i], e + 1 + i);
    end
    do_reset();

    // Wrap: nine forwarded samples.
    enable = 1'b1;
    for (int i = 1; i <= 9; i++) push(i * 3, e);
    idle(6);
    check("wrap_count", seen.size(), 9);
    for (int i = 0; i < 9; i++) begin
      check("wrap_data", seen[i], (i + 1) * 3);
      check("wrap_done", seen_done[i], ((i == 3) || (i == 7)) ? 1 : 0);
    end
    check("wrap_sample_count", 32'(sample_count), 32'd1);
    check("wrap_window_full", 32'(window_full), 32'd1);
    do_reset();
`else
    // Decimation by 2: push 1..8, only odd samples forwarded.
    enable = 1'b1;
    for (int i = 1; i <= 8; i++) push(i, e);
    idle(6);
    check("dec_count", seen.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check("dec_data", seen[i], 2 * i + 1);
      check("dec_done", seen_done[i], (i == 3) ? 1 : 0);
    end
    check("dec_sample_count", 32'(sample_count), 32'd0);
    check("dec_window_full", 32'(window_full), 32'd1);
    do_reset();
`endif

    // Randomized traffic against the model, with one reset mid-stream.
    th = 8;
    for (int i = 0; i < 3000; i++) begin
      if (i % 100 == 0) th = $urandom_range(0, 8);
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = DW'($urandom);
      enable   = ($urandom_range(0, 7) < th);
      @(negedge clk);
      if (i == 1500) do_reset();
    end
    idle(10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
